// File: rtl/lcd_pkg.sv
// Shared defaults for the 800x480 TFT raster: porch/sync timing, counter widths
// and the bundle of panel control bits that travels down the output pipeline.
package lcd_pkg;

  localparam int   LCD_H_ACTIVE = 800;
  localparam int   LCD_H_FP     = 210;
  localparam int   LCD_H_SYNC   = 20;
  localparam int   LCD_H_BP     = 26;
  localparam int   LCD_H_TOTAL  = LCD_H_ACTIVE + LCD_H_FP + LCD_H_SYNC + LCD_H_BP;

  localparam int   LCD_V_ACTIVE = 480;
  localparam int   LCD_V_FP     = 22;
  localparam int   LCD_V_SYNC   = 10;
  localparam int   LCD_V_BP     = 13;
  localparam int   LCD_V_TOTAL  = LCD_V_ACTIVE + LCD_V_FP + LCD_V_SYNC + LCD_V_BP;

  localparam logic LCD_SYNC_POL = 1'b0;
  localparam int   LCD_RGB_W    = 24;

  localparam int   H_CNT_W      = 11;
  localparam int   V_CNT_W      = 10;

  // Panel control bits, held at pin polarity once they enter the delay chain.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } sync_t;

endpackage

// File: rtl/lcd_sync_delay.sv
// Two-deep register chain that delays DE/HSYNC/VSYNC to line up with the
// registered renderer colour; syncs are converted to pin polarity on entry.
module lcd_sync_delay
  import lcd_pkg::*;
#(
  parameter logic SYNC_POL = LCD_SYNC_POL
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_de,
  input  logic  i_hsync_act,
  input  logic  i_vsync_act,
  output logic  o_de_mid,
  output sync_t o_pins
);

  localparam sync_t IDLE = '{de: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL};

  sync_t w_in;
  sync_t r_stage1;
  sync_t r_stage2;

  assign w_in = '{de:    i_de,
                  hsync: i_hsync_act ? SYNC_POL : ~SYNC_POL,
                  vsync: i_vsync_act ? SYNC_POL : ~SYNC_POL};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stage1 <= IDLE;
      r_stage2 <= IDLE;
    end else begin
      r_stage1 <= w_in;
      r_stage2 <= r_stage1;
    end
  end

  assign o_de_mid = r_stage1.de;
  assign o_pins   = r_stage2;

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator: h/v counters, one-stage-ahead pixel requests to the
// renderer, and cycle-aligned sync/DE/RGB panel outputs two clocks later.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int   H_ACTIVE = LCD_H_ACTIVE,
  parameter int   H_FP     = LCD_H_FP,
  parameter int   H_SYNC   = LCD_H_SYNC,
  parameter int   H_BP     = LCD_H_BP,
  parameter int   V_ACTIVE = LCD_V_ACTIVE,
  parameter int   V_FP     = LCD_V_FP,
  parameter int   V_SYNC   = LCD_V_SYNC,
  parameter int   V_BP     = LCD_V_BP,
  parameter logic SYNC_POL = LCD_SYNC_POL,
  parameter int   RGB_W    = LCD_RGB_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic               req_valid,
  output logic [H_CNT_W-1:0] req_x,
  output logic [V_CNT_W-1:0] req_y,
  output logic               frame_start,
  input  logic [RGB_W-1:0]   pix_rgb,
  output logic               lcd_hsync,
  output logic               lcd_vsync,
  output logic               lcd_de,
  output logic [RGB_W-1:0]   lcd_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_ACT_END  = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] H_SYNC_BEG = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] H_SYNC_END = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_ACT_END  = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_SYNC_BEG = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] V_SYNC_END = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_CNT_W-1:0] r_h_cnt;
  logic [V_CNT_W-1:0] r_v_cnt;

  logic               r_req_valid;
  logic [H_CNT_W-1:0] r_req_x;
  logic [V_CNT_W-1:0] r_req_y;
  logic               r_frame_start;
  logic               r_hsync_act;
  logic               r_vsync_act;
  logic [RGB_W-1:0]   r_lcd_rgb;

  logic               w_req;
  logic               w_h_sync;
  logic               w_v_sync;
  logic               w_origin;
  logic               w_de_mid;
  sync_t              w_pins;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the order of statements cannot create races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!en) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Everything below is gated by en so a disabled scan blanks on the next clock.
  assign w_req    = en && (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
  assign w_h_sync = en && (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
  assign w_v_sync = en && (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
  assign w_origin = en && (r_h_cnt == '0) && (r_v_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_valid   <= 1'b0;
      r_req_x       <= '0;
      r_req_y       <= '0;
      r_frame_start <= 1'b0;
      r_hsync_act   <= 1'b0;
      r_vsync_act   <= 1'b0;
    end else begin
      r_req_valid   <= w_req;
      r_req_x       <= w_req ? r_h_cnt : '0;
      r_req_y       <= w_req ? r_v_cnt : '0;
      r_frame_start <= w_origin;
      r_hsync_act   <= w_h_sync;
      r_vsync_act   <= w_v_sync;
    end
  end

  lcd_sync_delay #(
    .SYNC_POL (SYNC_POL)
  ) u_sync_delay (
    .clk         (clk),
    .reset       (reset),
    .i_de        (r_req_valid),
    .i_hsync_act (r_hsync_act),
    .i_vsync_act (r_vsync_act),
    .o_de_mid    (w_de_mid),
    .o_pins      (w_pins)
  );

  // Renderer colour is only meaningful in the clock after a request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lcd_rgb <= '0;
    end else begin
      r_lcd_rgb <= w_de_mid ? pix_rgb : '0;
    end
  end

  assign req_valid   = r_req_valid;
  assign req_x       = r_req_x;
  assign req_y       = r_req_y;
  assign frame_start = r_frame_start;
  assign lcd_de      = w_pins.de;
  assign lcd_hsync   = w_pins.hsync;
  assign lcd_vsync   = w_pins.vsync;
  assign lcd_rgb     = r_lcd_rgb;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench: a full-size instance for line timing and a shrunken,
// positive-polarity instance for whole-frame, enable and reset behaviour.
module tb_lcd_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic en;

  always #5 clk = ~clk;

  // Full 800x480 instance
  logic        f_req_valid, f_frame_start, f_lcd_hsync, f_lcd_vsync, f_lcd_de;
  logic [10:0] f_req_x;
  logic [9:0]  f_req_y;
  logic [23:0] f_pix_rgb = '0;
  logic [23:0] f_lcd_rgb;

  // 8x4 instance: H 8/3/2/3 = 16, V 4/2/2/1 = 9, frame = 144 clocks
  logic        s_req_valid, s_frame_start, s_lcd_hsync, s_lcd_vsync, s_lcd_de;
  logic [10:0] s_req_x;
  logic [9:0]  s_req_y;
  logic [23:0] s_pix_rgb = '0;
  logic [23:0] s_lcd_rgb;

  lcd_timing_gen u_full (
    .clk (clk), .reset (reset), .en (en),
    .req_valid (f_req_valid), .req_x (f_req_x), .req_y (f_req_y),
    .frame_start (f_frame_start), .pix_rgb (f_pix_rgb),
    .lcd_hsync (f_lcd_hsync), .lcd_vsync (f_lcd_vsync),
    .lcd_de (f_lcd_de), .lcd_rgb (f_lcd_rgb)
  );

  lcd_timing_gen #(
    .H_ACTIVE (8), .H_FP (3), .H_SYNC (2), .H_BP (3),
    .V_ACTIVE (4), .V_FP (2), .V_SYNC (2), .V_BP (1),
    .SYNC_POL (1'b1), .RGB_W (24)
  ) u_small (
    .clk (clk), .reset (reset), .en (en),
    .req_valid (s_req_valid), .req_x (s_req_x), .req_y (s_req_y),
    .frame_start (s_frame_start), .pix_rgb (s_pix_rgb),
    .lcd_hsync (s_lcd_hsync), .lcd_vsync (s_lcd_vsync),
    .lcd_de (s_lcd_de), .lcd_rgb (s_lcd_rgb)
  );

  // Renderer models: answer one clock after each request, junk otherwise.
  logic        f_prev_v = 1'b0, s_prev_v = 1'b0;
  logic [10:0] f_prev_x = '0, s_prev_x = '0;
  logic [9:0]  f_prev_y = '0, s_prev_y = '0;

  always @(negedge clk) begin
    f_pix_rgb = f_prev_v ? {f_prev_y[7:0], f_prev_x[7:0], 8'h5A} : 24'hBAD0BA;
    s_pix_rgb = s_prev_v ? {s_prev_y[7:0], s_prev_x[7:0], 8'h5A} : 24'hC0FFEE;
    f_prev_v = f_req_valid; f_prev_x = f_req_x; f_prev_y = f_req_y;
    s_prev_v = s_req_valid; s_prev_x = s_req_x; s_prev_y = s_req_y;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int f_req_cnt = 0, f_req_bad = 0, f_pin_bad = 0;
  int f_hs_cnt = 0, f_hs_first = -1, f_hs_last = -1;
  int s_req_cnt = 0, s_req_bad = 0, s_pin_bad = 0;
  int s_fs_n = 0, s_fs_t0 = -1, s_fs_t1 = -1;
  int s_de_lines = 0, s_vs_first = -1;
  logic s_de_prev = 1'b0;
  int fh, c, h, v;
  logic        exp_de, exp_hs, exp_vs, exp_req;
  logic [23:0] exp_rgb;
  int wait_k;

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_f_req_valid", f_req_valid, 0);
    check("rst_f_frame_start", f_frame_start, 0);
    check("rst_f_hsync", f_lcd_hsync, 1);
    check("rst_f_vsync", f_lcd_vsync, 1);
    check("rst_f_de", f_lcd_de, 0);
    check("rst_f_rgb", f_lcd_rgb, 0);
    check("rst_s_hsync", s_lcd_hsync, 0);
    check("rst_s_vsync", s_lcd_vsync, 0);

    reset = 1'b1;
    @(negedge clk);
    check("first_req_valid", f_req_valid, 1);
    check("first_req_x", f_req_x, 0);
    check("first_req_y", f_req_y, 0);
    check("first_frame_start", f_frame_start, 1);
    check("first_de_still_low", f_lcd_de, 0);

    // t counts clocks from the first request; pins at t show counter t-2.
    for (int t = 0; t < 1058; t++) begin
      if (t < 1056 && f_req_valid) f_req_cnt++;
      if (t < 1056 && f_req_valid && (f_req_x != 11'(t) || f_req_y != 10'd0)) f_req_bad++;
      if (t == 1) check("de_latency_1", f_lcd_de, 0);
      if (t == 2) begin
        check("de_latency_2", f_lcd_de, 1);
        check("first_rgb", f_lcd_rgb, 24'h00005A);
      end
      if (t == 1056) begin
        check("line_wrap_valid", f_req_valid, 1);
        check("line_wrap_x", f_req_x, 0);
        check("line_wrap_y", f_req_y, 1);
        check("line_wrap_no_fs", f_frame_start, 0);
      end

      fh      = t - 2;
      exp_de  = (t >= 2) && (fh < 800);
      exp_rgb = exp_de ? {8'h00, 8'(fh), 8'h5A} : 24'h0;
      if (f_lcd_de !== exp_de || f_lcd_rgb !== exp_rgb || f_lcd_vsync !== 1'b1) f_pin_bad++;
      if (t >= 2 && f_lcd_hsync === 1'b0) begin
        if (f_hs_cnt == 0) f_hs_first = fh;
        f_hs_last = fh;
        f_hs_cnt++;
      end

      c = t % 144; h = c % 16; v = c / 16;
      exp_req = (h < 8) && (v < 4);
      if (s_req_valid !== exp_req || s_frame_start !== (c == 0) ||
          (exp_req && (s_req_x != 11'(h) || s_req_y != 10'(v)))) s_req_bad++;
      if (t < 144 && s_req_valid) s_req_cnt++;
      if (s_frame_start) begin
        if (s_fs_n == 0) s_fs_t0 = t;
        else if (s_fs_n == 1) s_fs_t1 = t;
        s_fs_n++;
      end

      if (t >= 2) begin
        c = (t - 2) % 144; h = c % 16; v = c / 16;
        exp_de  = (h < 8) && (v < 4);
        exp_hs  = (h >= 11) && (h < 13);
        exp_vs  = (v >= 6) && (v < 8);
        exp_rgb = exp_de ? {8'(v), 8'(h), 8'h5A} : 24'h0;
      end else begin
        exp_de = 1'b0; exp_hs = 1'b0; exp_vs = 1'b0; exp_rgb = 24'h0;
      end
      if (s_lcd_de !== exp_de || s_lcd_hsync !== exp_hs ||
          s_lcd_vsync !== exp_vs || s_lcd_rgb !== exp_rgb) s_pin_bad++;
      if (t >= 2 && t < 146 && s_lcd_de && !s_de_prev) s_de_lines++;
      if (t >= 2 && t < 146 && s_lcd_vsync && s_vs_first < 0) s_vs_first = t - 2;
      s_de_prev = s_lcd_de;
      @(negedge clk);
    end

    check("f_req_count", f_req_cnt, 800);
    check("f_req_coords", f_req_bad, 0);
    check("f_pins_line0", f_pin_bad, 0);
    check("f_hsync_len", f_hs_cnt, 20);
    check("f_hsync_first", f_hs_first, 1010);
    check("f_hsync_last", f_hs_last, 1029);
    check("s_req_stream", s_req_bad, 0);
    check("s_req_per_frame", s_req_cnt, 32);
    check("s_fs_first", s_fs_t0, 0);
    check("s_fs_period", s_fs_t1, 144);
    check("s_fs_count", s_fs_n, 8);
    check("s_de_lines", s_de_lines, 4);
    check("s_vsync_first", s_vs_first, 96);
    check("s_pin_stream", s_pin_bad, 0);

    // Drop en while the small instance requests (3,2).
    wait_k = 0;
    while (!(s_req_valid && s_req_x == 11'd3 && s_req_y == 10'd2) && wait_k < 300) begin
      @(negedge clk);
      wait_k++;
    end
    check("en_drop_point_found", (wait_k < 300), 1);
    en = 1'b0;
    @(negedge clk);
    check("endrop_req_off", s_req_valid, 0);
    check("endrop_fs_off", s_frame_start, 0);
    check("endrop_flush_de", s_lcd_de, 1);
    @(negedge clk);
    check("endrop_last_rgb", s_lcd_rgb, 24'h02035A);
    @(negedge clk);
    check("endrop_de_low", s_lcd_de, 0);
    check("endrop_rgb_zero", s_lcd_rgb, 0);
    check("endrop_s_hsync", s_lcd_hsync, 0);
    check("endrop_s_vsync", s_lcd_vsync, 0);
    check("endrop_f_de", f_lcd_de, 0);
    check("endrop_f_req", f_req_valid, 0);
    repeat (5) @(negedge clk);
    check("hold_s_req", s_req_valid, 0);
    check("hold_f_hsync", f_lcd_hsync, 1);
    check("hold_f_vsync", f_lcd_vsync, 1);
    check("hold_f_rgb", f_lcd_rgb, 0);

    en = 1'b1;
    @(negedge clk);
    check("restart_s_valid", s_req_valid, 1);
    check("restart_s_xy", {s_req_y, s_req_x}, 0);
    check("restart_s_fs", s_frame_start, 1);
    check("restart_f_fs", f_frame_start, 1);
    @(negedge clk);
    check("restart_de_wait", s_lcd_de, 0);
    @(negedge clk);
    check("restart_s_de", s_lcd_de, 1);
    check("restart_s_rgb", s_lcd_rgb, 24'h00005A);
    repeat (3) @(negedge clk);
    check("pre_reset_f_de", f_lcd_de, 1);
    check("pre_reset_f_rgb", f_lcd_rgb, 24'h00035A);

    // Asynchronous reset between clock edges.
    #1 reset = 1'b0;
    #1;
    check("arst_f_req_valid", f_req_valid, 0);
    check("arst_f_req_x", f_req_x, 0);
    check("arst_f_frame_start", f_frame_start, 0);
    check("arst_f_de", f_lcd_de, 0);
    check("arst_f_rgb", f_lcd_rgb, 0);
    check("arst_f_hsync", f_lcd_hsync, 1);
    check("arst_f_vsync", f_lcd_vsync, 1);
    check("arst_s_de", s_lcd_de, 0);
    check("arst_s_hsync", s_lcd_hsync, 0);

    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rerelease_req", f_req_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
